// File: rtl/mul_pkg.sv
// Shared definitions for the 16x16 multiplier unit and its issue sequencer.
// Operand/product widths and the issue FSM state encoding.
package mul_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } issue_state_e;

endpackage

// File: rtl/mul_req_fifo.sv
// Request FIFO for the multiplier issue sequencer.
// Power-of-two depth; simultaneous push and pop allowed.
module mul_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue sequencer for the two-cycle multiplier: buffers tagged
// requests, issues one at a time and returns the tagged product.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic              mul_busy,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic [TAG_W-1:0]  out_tag,
  output logic              err
);

  localparam int EW = 2*OP_W + TAG_W;

  issue_state_e      state_q;
  logic [TAG_W-1:0]  infl_tag_q;
  logic              out_valid_q;
  logic [PROD_W-1:0] out_prod_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic              err_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              issue;
  logic [EW-1:0]     head;
  logic [TAG_W-1:0]  head_tag;

  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign head_tag = head[EW-1 -: TAG_W];
  assign mul_a    = head[2*OP_W-1 -: OP_W];
  assign mul_b    = head[OP_W-1:0];

  // Output slot must be free (or draining now) so S_CAPT never overwrites.
  assign issue = ~rst & (state_q == S_IDLE) & ~empty & ~mul_busy
               & (~out_valid_q | out_ready);

  assign mul_start = issue;

  mul_req_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({in_tag, in_a, in_b}),
    .pop   (issue),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      infl_tag_q  <= '0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      out_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (mul_done && state_q != S_WAIT) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (issue) begin
            infl_tag_q <= head_tag;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mul_done) state_q <= S_CAPT;
        end
        S_CAPT: begin
          out_prod_q  <= mul_prod;
          out_tag_q   <= infl_tag_q;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign out_tag   = out_tag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: behavioural multiplier, queue scoreboard,
// directed timing checks and a randomized traffic phase.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_tag;
  logic        mul_start;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;
  logic [3:0]  out_tag;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_issue_ctrl #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_prod(mul_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag), .err(err)
  );

  // Multiplier model: busy 2 cycles after start, done in the 2nd,
  // product visible from the cycle after done.
  int          mcnt;
  logic [15:0] ma_q;
  logic [15:0] mb_q;
  logic        inj_done;

  always @(posedge clk) begin
    if (rst) begin
      mcnt     <= 0;
      mul_prod <= '0;
    end else if (mul_start) begin
      ma_q <= mul_a;
      mb_q <= mul_b;
      mcnt <= 2;
    end else if (mcnt == 2) begin
      mcnt <= 1;
    end else if (mcnt == 1) begin
      mul_prod <= 32'(ma_q) * 32'(mb_q);
      mcnt     <= 0;
    end
  end

  assign mul_busy = (mcnt != 0);
  assign mul_done = (mcnt == 1) | inj_done;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] prod;
  } exp_t;

  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_prod", out_prod, e.prod);
          chk("sb_tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) begin
        e.tag  = in_tag;
        e.prod = 32'(in_a) * 32'(in_b);
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] t);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ba [5];
    logic [15:0] bb [5];
    logic [31:0] hold_p;
    logic [3:0]  hold_t;
    int          last;
    int          starts;
    int          n;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1; inj_done = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_prod", out_prod, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_err", err, 0);
    chk("rst_mul_start", mul_start, 0);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    // Single request: start in cycle 1, result in cycle 5.
    drive(16'h0003, 16'h0005, 4'd2);
    step();
    in_valid = 1'b0;
    chk("single_start", mul_start, 1);
    chk("single_mul_a", mul_a, 16'h0003);
    chk("single_mul_b", mul_b, 16'h0005);
    repeat (3) step();
    chk("single_c4_no_valid", out_valid, 0);
    step();
    chk("single_c5_valid", out_valid, 1);
    chk("single_prod", out_prod, 32'h0000000F);
    chk("single_tag", out_tag, 2);
    chk("single_err", err, 0);
    step();
    chk("single_drained", out_valid, 0);

    drive(16'hFFFF, 16'hFFFF, 4'd7);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("max_valid", out_valid, 1);
    chk("max_prod", out_prod, 32'hFFFE0001);
    step();
    repeat (2) step();

    // Burst of 5 with output stalled.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ba[k] = 16'($urandom);
      bb[k] = 16'($urandom);
      drive(ba[k], bb[k], 4'(k));
      step();
    end
    in_valid = 1'b0;
    chk("burst_full", in_ready, 0);
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      if (mul_start) starts++;
      step();
    end
    chk("burst_stall_no_start", starts, 0);
    chk("burst_hold_tag0", out_tag, 0);
    out_ready = 1'b1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_out("burst");
      chk("burst_tag", out_tag, k);
      chk("burst_prod", out_prod, 32'(ba[k]) * 32'(bb[k]));
      if (k > 0) chk("burst_spacing", cyc - last, 4);
      last = cyc;
      step();
    end
    repeat (2) step();

    // Output backpressure with a second request queued.
    out_ready = 1'b0;
    drive(16'h1234, 16'h0010, 4'd9);
    step();
    drive(16'h0002, 16'h0003, 4'd10);
    step();
    in_valid = 1'b0;
    wait_out("bp");
    hold_p = out_prod;
    hold_t = out_tag;
    chk("bp_prod", hold_p, 32'h00012340);
    starts = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (mul_start) starts++;
      if (out_prod !== hold_p || out_tag !== hold_t || !out_valid) n++;
      step();
    end
    chk("bp_no_start", starts, 0);
    chk("bp_stable", n, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_start", mul_start, 1);
    step();
    wait_out("bp2");
    chk("bp2_tag", out_tag, 10);
    chk("bp2_prod", out_prod, 32'd6);
    step();
    repeat (2) step();

    // Spurious done while idle.
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    chk("perr_set", err, 1);
    chk("perr_out_valid", out_valid, 0);
    chk("perr_in_ready", in_ready, 1);
    repeat (5) step();
    chk("perr_sticky", err, 1);
    drive(16'd6, 16'd7, 4'd3);
    step();
    in_valid = 1'b0;
    wait_out("perr_req");
    chk("perr_req_prod", out_prod, 32'd42);
    chk("perr_req_tag", out_tag, 3);
    step();
    repeat (2) step();

    // Reset while waiting on the multiplier with requests queued.
    drive(16'd11, 16'd12, 4'd4);
    step();
    drive(16'd13, 16'd14, 4'd5);
    step();
    drive(16'd15, 16'd16, 4'd6);
    step();
    drive(16'd17, 16'd18, 4'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("wrst_out_valid", out_valid, 0);
    chk("wrst_in_ready", in_ready, 1);
    chk("wrst_err", err, 0);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      if (mul_start || out_valid) starts++;
      step();
    end
    chk("wrst_quiet", starts, 0);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 2) == 0;
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    chk("rand_drained", q.size(), 0);
    chk("rand_out_idle", out_valid, 0);
    chk("rand_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
